// File: rtl/fifo_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_access_arbiter
// Purpose  : Shares a single DATA_W x DEPTH FIFO between NUM_REQ producers and
//            one consumer. Producers are served round-robin with a limit on
//            consecutive pushes per grant. Push and pop are never issued in the
//            same cycle, and an internal occupancy count stops a push to a full
//            FIFO or a pop from an empty one.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            en         - arbiter enable, forwarded registered as fifo_en
//            req/wdata  - producer requests and data (slice i = producer i)
//            gnt        - one-hot, combinational: slice taken at this edge
//            pop_req    - consumer wants one word
//            pop_ack    - combinational: pop issued at this edge
//            fifo_en/fifo_push/fifo_pop/fifo_din - registered FIFO controls
//            level      - occupancy count, 0..DEPTH
//            stall_cnt  - stall statistics
// Options  : FIFO_ACCESS_ARB_STATS_EN - when defined, stall_cnt counts cycles
//            with a pending request, en high and no grant (saturating).
//            When undefined, stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_access_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic                        pop_req,
    output logic                        pop_ack,
    output logic                        fifo_en,
    output logic                        fifo_push,
    output logic                        fifo_pop,
    output logic [DATA_W-1:0]           fifo_din,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic [15:0]                 stall_cnt
);

    localparam int c_ptr_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_scan_w = c_ptr_w + 1;
    localparam int c_lvl_w  = $clog2(DEPTH + 1);
    localparam int c_cnt_w  = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_ptr_w-1:0]   owner_q, owner_d;
    logic [c_ptr_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_cnt_w-1:0]   burst_cnt_q, burst_cnt_d;
    logic [c_lvl_w-1:0]   level_q, level_d;
    logic                 prio_q, prio_d;       // 0: pop wins next conflict
    logic                 fifo_en_q, fifo_en_d;
    logic                 fifo_push_q, fifo_push_d;
    logic                 fifo_pop_q, fifo_pop_d;
    logic [DATA_W-1:0]    fifo_din_q, fifo_din_d;

    logic [c_scan_w-1:0]  w_scan;
    logic [c_ptr_w-1:0]   w_cand;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_owner;
    logic                 w_has_owner;
    logic                 w_push_elig;
    logic                 w_pop_elig;
    logic                 w_conflict;
    logic                 w_pop_win;
    logic                 w_push_win;
    logic [c_cnt_w-1:0]   w_cnt_inc;

    function automatic logic [c_ptr_w-1:0] inc_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after rr_ptr, cyclic.
    always_comb begin
        w_cand  = rr_ptr_q;
        w_found = 1'b0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, rr_ptr_q} + c_scan_w'(k);
            if (w_scan >= c_scan_w'(NUM_REQ)) begin
                w_scan = w_scan - c_scan_w'(NUM_REQ);
            end
            if (!w_found && req[w_scan[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_cand  = w_scan[c_ptr_w-1:0];
            end
        end
    end

    // In IDLE the candidate is granted in the same cycle it is chosen, so a
    // hand-over between owners costs no bubble. Both combinational outputs
    // are gated by rst so they read 0 while reset is held.
    always_comb begin
        w_has_owner = (state_q == ST_BURST) || (en && (|req));
        w_owner     = (state_q == ST_BURST) ? owner_q : w_cand;
        w_push_elig = rst && w_has_owner && req[w_owner] && en &&
                      (level_q < c_lvl_w'(DEPTH));
        w_pop_elig  = rst && pop_req && en && (level_q != '0);
        w_conflict  = w_push_elig && w_pop_elig;
        w_pop_win   = w_pop_elig && (!w_push_elig || !prio_q);
        w_push_win  = w_push_elig && !w_pop_win;
        gnt         = '0;
        if (w_push_win) begin
            gnt[w_owner] = 1'b1;
        end
        pop_ack     = w_pop_win;
        w_cnt_inc   = burst_cnt_q + c_cnt_w'(w_push_win);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en && (|req)) begin
                    if (w_cnt_inc == c_cnt_w'(MAX_BURST)) begin
                        // Single-word burst: done already, stay idle.
                        rr_ptr_d    = inc_ptr(w_cand);
                        burst_cnt_d = '0;
                    end else begin
                        state_d     = ST_BURST;
                        owner_d     = w_cand;
                        burst_cnt_d = w_cnt_inc;
                    end
                end
            end
            ST_BURST: begin
                if (!req[owner_q] || !en || (w_cnt_inc == c_cnt_w'(MAX_BURST))) begin
                    state_d     = ST_IDLE;
                    rr_ptr_d    = inc_ptr(owner_q);
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = w_cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        level_d     = level_q + c_lvl_w'(w_push_win) - c_lvl_w'(w_pop_win);
        prio_d      = w_conflict ? !prio_q : prio_q;
        fifo_en_d   = en;
        fifo_push_d = w_push_win;
        fifo_pop_d  = w_pop_win;
        fifo_din_d  = w_push_win ? wdata[w_owner*DATA_W +: DATA_W] : fifo_din_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            level_q     <= '0;
            prio_q      <= 1'b0;
            fifo_en_q   <= 1'b0;
            fifo_push_q <= 1'b0;
            fifo_pop_q  <= 1'b0;
            fifo_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            level_q     <= level_d;
            prio_q      <= prio_d;
            fifo_en_q   <= fifo_en_d;
            fifo_push_q <= fifo_push_d;
            fifo_pop_q  <= fifo_pop_d;
            fifo_din_q  <= fifo_din_d;
        end
    end

    assign fifo_en   = fifo_en_q;
    assign fifo_push = fifo_push_q;
    assign fifo_pop  = fifo_pop_q;
    assign fifo_din  = fifo_din_q;
    assign level     = level_q;

`ifdef FIFO_ACCESS_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req) && en && !(|gnt) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_access_arbiter
// Purpose  : Self-checking bench for fifo_access_arbiter: directed vector
//            table, hand-written corner sequences and randomized traffic
//            against a behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_access_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 4;
`ifdef FIFO_ACCESS_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       en;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  wdata;
    logic [NUM_REQ-1:0]         gnt;
    logic                       pop_req;
    logic                       pop_ack;
    logic                       fifo_en;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic [DATA_W-1:0]          fifo_din;
    logic [4:0]                 level;
    logic [15:0]                stall_cnt;

    fifo_access_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst_n), .en(en), .req(req), .wdata(wdata), .gnt(gnt),
        .pop_req(pop_req), .pop_ack(pop_ack), .fifo_en(fifo_en),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_din(fifo_din),
        .level(level), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int        m_owner;     // -1: nobody holds the grant
    int        m_cnt, m_rr, m_level, m_stall;
    bit        m_pop_first;
    bit        m_push, m_pop, m_en;
    logic [7:0] m_din;
    logic [3:0] s_gnt;      // gnt/pop_ack as sampled in the last cycle
    logic       s_ack;

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_rr = 0; m_level = 0; m_stall = 0;
        m_pop_first = 1'b1; m_push = 0; m_pop = 0; m_en = 0; m_din = '0;
    endtask

    task automatic do_cycle();
        logic [3:0] eg;
        logic       ea;
        int         o;
        bit         push_ok, pop_ok, conflict, found;
        eg = '0; ea = 1'b0; o = -1; found = 0;
        if (m_owner >= 0) o = m_owner;
        else if (en && req != 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[(m_rr + k) % NUM_REQ]) begin
                    o = (m_rr + k) % NUM_REQ;
                    found = 1;
                end
            end
        end
        push_ok  = (o >= 0) && req[o] && en && (m_level < DEPTH);
        pop_ok   = pop_req && en && (m_level > 0);
        conflict = push_ok && pop_ok;
        if (conflict) begin
            if (m_pop_first) ea = 1'b1; else eg[o] = 1'b1;
        end else if (push_ok) eg[o] = 1'b1;
        else if (pop_ok) ea = 1'b1;

        @(negedge clk);
        s_gnt = gnt;
        s_ack = pop_ack;
        check("gnt", gnt, eg);
        check("pop_ack", pop_ack, ea);
        @(posedge clk);
        if (conflict) m_pop_first = !m_pop_first;
        if (eg != 0) begin m_level++; m_cnt++; m_din = wdata[o*DATA_W +: DATA_W]; end
        if (ea) m_level--;
        if (req != 0 && en && eg == 0 && m_stall < 65535) m_stall++;
        if (o >= 0) begin
            if (!req[o] || !en || m_cnt == MAX_BURST) begin
                m_owner = -1; m_cnt = 0; m_rr = (o + 1) % NUM_REQ;
            end else m_owner = o;
        end
        m_push = (eg != 0); m_pop = ea; m_en = en;
        #1;
        cyc++;
        check("fifo_push", fifo_push, m_push);
        check("fifo_pop", fifo_pop, m_pop);
        check("fifo_din", fifo_din, m_din);
        check("fifo_en", fifo_en, m_en);
        check("level", level, m_level);
        check("stall_cnt", stall_cnt, STATS ? m_stall : 0);
    endtask

    // Called at posedge+1; asserts reset asynchronously and releases it one
    // edge later.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst gnt", gnt, 0);
        check("rst pop_ack", pop_ack, 0);
        check("rst fifo_push", fifo_push, 0);
        check("rst fifo_pop", fifo_pop, 0);
        check("rst fifo_en", fifo_en, 0);
        check("rst fifo_din", fifo_din, 0);
        check("rst level", level, 0);
        check("rst stall_cnt", stall_cnt, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_in(input bit e, input logic [3:0] r, input bit p);
        en = e; req = r; pop_req = p; wdata = $urandom;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst_n;
        bit         en;
        logic [3:0] req;
        bit         pop;
        logic [3:0] exp_gnt;
        bit         exp_ack;
        int         exp_level;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit e, input logic [3:0] q, input bit p,
                       input logic [3:0] g, input bit a, input int l);
        vec_t v;
        v.rst_n = r; v.en = e; v.req = q; v.pop = p;
        v.exp_gnt = g; v.exp_ack = a; v.exp_level = l;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = '0; pop_req = 1'b0; wdata = '0;
        model_reset();

        // Round-robin with all producers requesting.
        add(0, 1, 4'b1111, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 15; i++)
            add(1, 1, 4'b1111, 0, 4'b0001 << (i / 4), 0, i + 1);
        // Conflict: five words from producer 0, then push/pop alternate.
        add(0, 1, 4'b0001, 0, 4'b0000, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 4'b0001, 0, 4'b0001, 0, i + 1);
        add(1, 1, 4'b0001, 1, 4'b0000, 1, 4);
        add(1, 1, 4'b0001, 1, 4'b0001, 0, 5);
        add(1, 1, 4'b0001, 1, 4'b0000, 1, 4);
        add(1, 1, 4'b0001, 1, 4'b0001, 0, 5);
        add(1, 0, 4'b0001, 1, 4'b0000, 0, 5);
        add(1, 1, 4'b0000, 1, 4'b0000, 1, 4);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            if (!vecs[i].rst_n) begin
                set_in(vecs[i].en, vecs[i].req, vecs[i].pop);
                do_reset();
            end else begin
                set_in(vecs[i].en, vecs[i].req, vecs[i].pop);
                do_cycle();
                check("vec gnt", s_gnt, vecs[i].exp_gnt);
                check("vec pop_ack", s_ack, vecs[i].exp_ack);
                check("vec level", level, vecs[i].exp_level);
            end
        end

        // Fill from producer 2, stall on full, owner retained.
        set_in(1, 4'b0000, 0);
        do_reset();
        for (int i = 0; i < 16; i++) begin set_in(1, 4'b0100, 0); do_cycle(); end
        check("fill level", level, 16);
        for (int i = 0; i < 10; i++) begin
            set_in(1, 4'b0100, 0); do_cycle();
            if (i == 0) begin
                check("full gnt", s_gnt, 0);
                check("full fifo_push", fifo_push, 0);
            end
        end
        check("stats stall_cnt", stall_cnt, STATS ? 10 : 0);
        set_in(1, 4'b1110, 0); do_cycle();
        set_in(1, 4'b1110, 1); do_cycle();
        check("full pop_ack", s_ack, 1);
        set_in(1, 4'b1110, 0); do_cycle();
        check("owner kept", s_gnt, 4'b0100);

        // Empty: pops refused until the first push lands.
        set_in(1, 4'b0000, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4'b0000, 1); do_cycle();
            check("empty pop_ack", s_ack, 0);
            check("empty fifo_pop", fifo_pop, 0);
        end
        set_in(1, 4'b0001, 1); do_cycle();
        check("empty push gnt", s_gnt, 4'b0001);
        set_in(1, 4'b0000, 1); do_cycle();
        check("pop after push", s_ack, 1);
        check("pop after push fifo_pop", fifo_pop, 1);

        // Asynchronous reset in the middle of a burst.
        set_in(1, 4'b0000, 0);
        do_reset();
        for (int i = 0; i < 2; i++) begin set_in(1, 4'b0010, 0); do_cycle(); end
        check("burst level", level, 2);
        do_reset();
        set_in(1, 4'b0011, 0); do_cycle();
        check("restart at 0", s_gnt, 4'b0001);

        // Randomized traffic, two pop-pressure phases, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int pp;
            pp = ((i / 250) % 2 == 0) ? 3 : 1;   // pop probability in quarters
            if (i % 700 == 699) begin
                set_in(1, 4'($urandom), 1'($urandom));
                do_reset();
            end
            set_in(($urandom % 8) != 0, 4'($urandom), ($urandom % 4) < pp);
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
